// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between the I-cache and D-cache miss paths.
// Build option ARB_ROUND_ROBIN_EN: alternate grants under contention (default: D over I).
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;
  state_t                r_state;
  logic                  r_read;
  logic                  r_write;
  logic                  r_last_d;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic                  w_i_req;
  logic                  w_d_req;
  logic                  w_pick_d;
  assign w_i_req = i_pmem_read;
  assign w_d_req = d_pmem_read | d_pmem_write;
`ifdef ARB_ROUND_ROBIN_EN
  assign w_pick_d = w_d_req & (~w_i_req | ~r_last_d);
`else
  assign w_pick_d = w_d_req;
`endif
  assign mem_read     = r_read;
  assign mem_write    = r_write;
  assign mem_address  = r_addr;
  assign mem_wdata    = r_wdata;
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  assign i_pmem_resp  = (r_state == SERVE_I) & mem_resp;
  assign d_pmem_resp  = (r_state == SERVE_D) & mem_resp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_last_d <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state <= SERVE_D;
            r_read  <= ~d_pmem_write;
            r_write <= d_pmem_write;
            r_addr  <= d_pmem_address;
            r_wdata <= d_pmem_write ? d_pmem_wdata : '0;
          end else if (w_i_req) begin
            r_state <= SERVE_I;
            r_read  <= 1'b1;
            r_write <= 1'b0;
            r_addr  <= i_pmem_address;
            r_wdata <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            r_state  <= DONE;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_last_d <= (r_state == SERVE_D);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(d_pmem_read && d_pmem_write));
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: cycle-by-cycle vector table plus hand sequences for reset and spurious responses.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [LW-1:0] L_A5 = {32{8'hA5}};
  localparam logic [LW-1:0] L_5A = {32{8'h5A}};
  localparam logic [LW-1:0] L_ONES = '1;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  int checks = 0;
  int failures = 0;
  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic ir; logic [AW-1:0] ia; logic dr; logic dw; logic [AW-1:0] da; logic [LW-1:0] dwd;
    logic mr; logic [LW-1:0] mrd;
    logic er; logic ew; logic [AW-1:0] ea; logic [LW-1:0] ewd; logic eir; logic edr;
  } vec_t;
  vec_t v[$];
  function automatic vec_t mk(logic ir, logic [AW-1:0] ia, logic dr, logic dw, logic [AW-1:0] da,
                              logic [LW-1:0] dwd, logic mr, logic [LW-1:0] mrd, logic er, logic ew,
                              logic [AW-1:0] ea, logic [LW-1:0] ewd, logic eir, logic edr);
    vec_t t;
    t = '{ir, ia, dr, dw, da, dwd, mr, mrd, er, ew, ea, ewd, eir, edr};
    return t;
  endfunction
  task automatic chk(string n, logic [LW-1:0] a, logic [LW-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic drive(vec_t t);
    i_pmem_read = t.ir; i_pmem_address = t.ia;
    d_pmem_read = t.dr; d_pmem_write = t.dw; d_pmem_address = t.da; d_pmem_wdata = t.dwd;
    mem_resp = t.mr; mem_rdata = t.mrd;
  endtask
  initial begin
    logic [AW-1:0] a_c1, a_c2;
    a_c1 = RR ? 32'h1040 : 32'h2000;
    a_c2 = RR ? 32'h2000 : 32'h1040;
    // I-only read, five-cycle memory latency, spurious resp in DONE
    v.push_back(mk(1, 32'h1040, 0, 0, 0, 0, 0, 0,      0, 0, 0,          0, 0, 0));
    for (int k = 1; k <= 4; k++)
      v.push_back(mk(1, 32'h1040, 0, 0, 0, 0, 0, 0,    1, 0, 32'h1040,   0, 0, 0));
    v.push_back(mk(1, 32'h1040, 0, 0, 0, 0, 1, L_A5,   1, 0, 32'h1040,   0, 1, 0));
    v.push_back(mk(0, 32'h1040, 0, 0, 0, 0, 1, L_5A,   0, 0, 32'h1040,   0, 0, 0));
    v.push_back(mk(0, 32'h1040, 0, 0, 0, 0, 0, 0,      0, 0, 32'h1040,   0, 0, 0));
    // D write-back then D read, two idle cycles between commands
    v.push_back(mk(0, 0, 0, 1, 32'h8000_0000, L_ONES, 0, 0,    0, 0, 32'h1040,      0, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 32'h8000_0000, L_ONES, 0, 0,    0, 1, 32'h8000_0000, L_ONES, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 32'h8000_0000, L_ONES, 1, 0,    0, 1, 32'h8000_0000, L_ONES, 0, 1));
    v.push_back(mk(0, 0, 1, 0, 32'h8000_0020, 0, 0, 0,         0, 0, 32'h8000_0000, L_ONES, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 32'h8000_0020, 0, 0, 0,         0, 0, 32'h8000_0000, L_ONES, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 32'h8000_0020, 0, 0, 0,         1, 0, 32'h8000_0020, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 32'h8000_0020, 0, 1, L_5A,      1, 0, 32'h8000_0020, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 32'h8000_0020, 0, 0, 0,         0, 0, 32'h8000_0020, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 32'h8000_0020, 0, 0, 0));
    // Simultaneous I and D requests (last grant was D)
    v.push_back(mk(1, 32'h1040, 1, 0, 32'h2000, 0, 0, 0,       0, 0, 32'h8000_0020, 0, 0, 0));
    v.push_back(mk(1, 32'h1040, 1, 0, 32'h2000, 0, 0, 0,       1, 0, a_c1, 0, 0, 0));
    v.push_back(mk(1, 32'h1040, 1, 0, 32'h2000, 0, 1, L_A5,    1, 0, a_c1, 0, RR, !RR));
    v.push_back(mk(!RR, 32'h1040, RR, 0, 32'h2000, 0, 0, 0,    0, 0, a_c1, 0, 0, 0));
    v.push_back(mk(!RR, 32'h1040, RR, 0, 32'h2000, 0, 0, 0,    0, 0, a_c1, 0, 0, 0));
    v.push_back(mk(!RR, 32'h1040, RR, 0, 32'h2000, 0, 1, L_5A, 1, 0, a_c2, 0, !RR, RR));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, a_c2, 0, 0, 0));
    // Address changes mid-SERVE_D must not reach memory
    v.push_back(mk(0, 0, 1, 0, 32'h100, 0, 0, 0,               0, 0, a_c2, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 32'h200, 0, 0, 0,               1, 0, 32'h100, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 32'h200, 0, 0, 0,               1, 0, 32'h100, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 32'h200, 0, 1, L_A5,            1, 0, 32'h100, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 32'h100, 0, 0, 0));
    // Spurious resp in IDLE, then a grant proves the state stayed IDLE
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, L_5A,                  0, 0, 32'h100, 0, 0, 0));
    v.push_back(mk(1, 32'h3000, 0, 0, 0, 0, 0, 0,              0, 0, 32'h100, 0, 0, 0));
    v.push_back(mk(1, 32'h3000, 0, 0, 0, 0, 0, 0,              1, 0, 32'h3000, 0, 0, 0));
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1;
    chk("rst mem_read", LW'(mem_read), 0);
    chk("rst mem_write", LW'(mem_write), 0);
    chk("rst mem_address", LW'(mem_address), 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst i_resp", LW'(i_pmem_resp), 0);
    chk("rst d_resp", LW'(d_pmem_resp), 0);
    rst_n = 1'b1;
    foreach (v[i]) begin
      @(negedge clk);
      drive(v[i]);
      #1;
      chk($sformatf("v%0d mem_read", i), LW'(mem_read), LW'(v[i].er));
      chk($sformatf("v%0d mem_write", i), LW'(mem_write), LW'(v[i].ew));
      chk($sformatf("v%0d mem_address", i), LW'(mem_address), LW'(v[i].ea));
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, v[i].ewd);
      chk($sformatf("v%0d i_resp", i), LW'(i_pmem_resp), LW'(v[i].eir));
      chk($sformatf("v%0d d_resp", i), LW'(d_pmem_resp), LW'(v[i].edr));
      chk($sformatf("v%0d i_rdata", i), i_pmem_rdata, v[i].mrd);
      chk($sformatf("v%0d d_rdata", i), d_pmem_rdata, v[i].mrd);
    end
    // Reset during SERVE_I aborts the transaction without a late resp
    @(negedge clk);
    i_pmem_read = 1'b0;
    mem_resp = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort mem_read", LW'(mem_read), 0);
    chk("abort mem_address", LW'(mem_address), 0);
    mem_resp = 1'b1;
    #1;
    chk("abort i_resp", LW'(i_pmem_resp), 0);
    chk("abort d_resp", LW'(d_pmem_resp), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post-rst i_resp", LW'(i_pmem_resp), 0);
    chk("post-rst mem_read", LW'(mem_read), 0);
    mem_resp = 1'b0;
    i_pmem_read = 1'b1;
    i_pmem_address = 32'h40;
    @(negedge clk);
    #1;
    chk("post-rst grant mem_read", LW'(mem_read), 1);
    chk("post-rst grant mem_address", LW'(mem_address), 32'h40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
